// File: rtl/lwe_encrypt.sv
// LWE public-key encryptor: sums mask-selected PK rows column-wise mod q, adds the
// plaintext to column 0, then streams the DIMENSION+1 ciphertext entries out.
module lwe_encrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 10,
    parameter int DIM_WIDTH          = 4,
    parameter int BIG_N              = 30,
    parameter int ROW_WIDTH          = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
    input  logic [BIG_N-1:0]            rand_mask,
    output logic                        busy,
    output logic                        pk_rd_en,
    output logic [ROW_WIDTH-1:0]        pk_row_addr,
    output logic [DIM_WIDTH:0]          pk_col_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0] pk_entry,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] ct_entry,
    output logic [DIM_WIDTH:0]          ct_index,
    output logic                        done
);

    // Modular reduction is plain truncation, so both moduli must be powers of two.
    generate
        if (CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH) ||
            PLAINTEXT_MODULUS  != (1 << PLAINTEXT_WIDTH)) begin : g_bad_cfg
            $error("lwe_encrypt: moduli must equal 2**width");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, SCAN, READ, FINAL, OUT} state_t;

    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(BIG_N);
    localparam logic [DIM_WIDTH:0]   LAST_COL = (DIM_WIDTH+1)'(DIMENSION);

    state_t                                      state;
    logic [PLAINTEXT_WIDTH-1:0]                  pt_q;
    logic [BIG_N-1:0]                            mask_q;
    logic [ROW_WIDTH-1:0]                        row;
    logic [DIM_WIDTH:0]                          out_idx;
    logic                                        rd_vld;
    logic [DIM_WIDTH:0]                          rd_col;
    logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]    acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pt_q        <= '0;
            mask_q      <= '0;
            row         <= '0;
            out_idx     <= '0;
            rd_vld      <= 1'b0;
            rd_col      <= '0;
            acc         <= '0;
            pk_rd_en    <= 1'b0;
            pk_row_addr <= '0;
            pk_col_addr <= '0;
            ct_valid    <= 1'b0;
        end else begin
            // Read data lands one cycle after issue, whatever state the FSM is in by then.
            if (rd_vld) begin
                for (int i = 0; i <= DIMENSION; i++) begin
                    if (rd_col == (DIM_WIDTH+1)'(i))
                        acc[i] <= acc[i] + pk_entry;
                end
            end
            rd_vld <= 1'b0;
            rd_col <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        pt_q   <= plaintext;
                        mask_q <= rand_mask;
                        acc    <= '0;
                        row    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (row == LAST_ROW) begin
                        state <= FINAL;
                    end else if (mask_q[row]) begin
                        pk_rd_en    <= 1'b1;
                        pk_row_addr <= row;
                        pk_col_addr <= '0;
                        state       <= READ;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                READ: begin
                    rd_vld <= 1'b1;
                    rd_col <= pk_col_addr;
                    if (pk_col_addr == LAST_COL) begin
                        pk_rd_en    <= 1'b0;
                        pk_row_addr <= '0;
                        pk_col_addr <= '0;
                        row         <= row + 1'b1;
                        state       <= SCAN;
                    end else begin
                        pk_col_addr <= pk_col_addr + 1'b1;
                    end
                end
                FINAL: begin
                    acc[0]   <= acc[0] + {{(CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH){1'b0}}, pt_q};
                    out_idx  <= '0;
                    ct_valid <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (ct_ready) begin
                        if (out_idx == LAST_COL) begin
                            ct_valid <= 1'b0;
                            out_idx  <= '0;
                            state    <= IDLE;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ct_entry = '0;
        for (int i = 0; i <= DIMENSION; i++) begin
            if (ct_valid && out_idx == (DIM_WIDTH+1)'(i))
                ct_entry = acc[i];
        end
    end

    assign busy     = (state != IDLE);
    assign ct_index = out_idx;
    assign done     = ct_valid && ct_ready && (out_idx == LAST_COL);

endmodule

// File: tb/tb_lwe_encrypt.sv
// Scoreboard bench for lwe_encrypt: column sums from a PK array model, plus an
// LWE decrypt round trip driven by ct_index.
module tb_lwe_encrypt;
    localparam int PW = 6, CW = 10, D = 10, DW = 4, N = 30, RW = 5, Q = 1024;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [PW-1:0] plaintext = '0;
    logic [N-1:0]  rand_mask = '0;
    logic          busy, pk_rd_en, ct_valid, done;
    logic [RW-1:0] pk_row_addr;
    logic [DW:0]   pk_col_addr, ct_index;
    logic [CW-1:0] pk_entry = '0;
    logic          ct_ready = 1'b1;
    logic [CW-1:0] ct_entry;

    always #5 clk = ~clk;

    lwe_encrypt dut (
        .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext),
        .rand_mask(rand_mask), .busy(busy), .pk_rd_en(pk_rd_en),
        .pk_row_addr(pk_row_addr), .pk_col_addr(pk_col_addr), .pk_entry(pk_entry),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_entry(ct_entry),
        .ct_index(ct_index), .done(done)
    );

    // PK memory: one-cycle read latency, garbage on the bus when not reading.
    logic [CW-1:0] pk_mem [0:31][0:31];
    always @(posedge clk)
        pk_entry <= pk_rd_en ? pk_mem[pk_row_addr][pk_col_addr] : CW'($urandom);

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    int tests = 0, fails = 0;
    int rd_cnt = 0, done_cnt = 0, c0 = 0, exp_lat = 0;
    logic [CW-1:0] exp_e[$];
    logic [DW:0]   exp_i[$];
    bit  rt_mode = 1'b0, prev_valid = 1'b0;
    int  key [0:D];
    int  rt_pt = 0, dec = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (pk_rd_en) begin
                rd_cnt++;
                chk("rd_en_while_busy", int'(busy), 1);
            end else begin
                chk("idle_pk_addr", int'(pk_row_addr) + int'(pk_col_addr), 0);
            end
            if (ct_valid && !prev_valid)
                chk("latency", cyc - c0, exp_lat);
            prev_valid = ct_valid;
            if (ct_valid && ct_ready) begin
                if (exp_e.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: got index %0d entry %0d, none expected",
                             ct_index, ct_entry);
                end else begin
                    chk("ct_entry", int'(ct_entry), int'(exp_e.pop_front()));
                    chk("ct_index", int'(ct_index), int'(exp_i.pop_front()));
                end
                if (rt_mode && int'(ct_index) <= D)
                    dec = (dec + int'(ct_entry) * key[int'(ct_index)]) % Q;
            end
            if (done) begin
                done_cnt++;
                chk("done_on_last", int'(ct_valid && ct_ready && int'(ct_index) == D), 1);
                if (rt_mode) chk("roundtrip", dec % 64, rt_pt);
                dec = 0;
            end
        end
    end

    task automatic fill_const(input int v);
        for (int r = 0; r < 32; r++)
            for (int j = 0; j < 32; j++) pk_mem[r][j] = CW'(v);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 32; r++)
            for (int j = 0; j < 32; j++) pk_mem[r][j] = CW'($urandom);
    endtask

    // Row i: (b_i, a_i) with b_i = -<a_i,s> + 64*e_i, so (1,s) decrypts to m + 64*E.
    task automatic fill_lwe();
        fill_rand();
        key[0] = 1;
        for (int j = 1; j <= D; j++) key[j] = int'($urandom_range(0, Q-1));
        for (int r = 0; r < N; r++) begin
            int dot, a, e;
            dot = 0;
            for (int j = 1; j <= D; j++) begin
                a = int'($urandom_range(0, Q-1));
                pk_mem[r][j] = CW'(a);
                dot = (dot + a * key[j]) % Q;
            end
            e = int'($urandom_range(0, 2)) - 1;
            pk_mem[r][0] = CW'((2*Q - dot + 64*e) % Q);
        end
    endtask

    // mode 0: always ready; 1: hold at index 4 for 7 cycles + stray starts; 2: random ready
    task automatic run_enc(input int pt, input logic [N-1:0] m, input int mode);
        int k, t, d0, sum;
        bit bp_done;
        logic [CW-1:0] he;
        logic [DW:0]   hi;
        t = 0;
        while (busy && t < 2000) begin step(); t++; end
        chk("idle_before_start", int'(busy), 0);
        k = $countones(m);
        for (int j = 0; j <= D; j++) begin
            sum = (j == 0) ? pt : 0;
            for (int r = 0; r < N; r++) if (m[r]) sum += int'(pk_mem[r][j]);
            exp_e.push_back(CW'(sum % Q));
            exp_i.push_back((DW+1)'(j));
        end
        exp_lat = N + k*(D+1) + 3;
        rd_cnt = 0;
        d0 = done_cnt;
        rt_pt = pt;
        dec = 0;
        plaintext = PW'(pt);
        rand_mask = m;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        plaintext = PW'($urandom);
        rand_mask = N'($urandom);
        bp_done = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            if (mode == 2) ct_ready = ($urandom % 4) != 0;
            if (mode == 1) begin
                start = 1'b0;
                if (!bp_done && ct_valid && int'(ct_index) == 4) begin
                    ct_ready = 1'b0;
                    he = ct_entry;
                    hi = ct_index;
                    repeat (7) begin
                        step(); t++;
                        chk("hold_entry", int'(ct_entry), int'(he));
                        chk("hold_index", int'(ct_index), int'(hi));
                        chk("hold_valid", int'(ct_valid), 1);
                    end
                    ct_ready = 1'b1;
                    bp_done = 1'b1;
                end else if (busy && ($urandom % 5) == 0) begin
                    start = 1'b1;
                    plaintext = PW'($urandom);
                    rand_mask = N'($urandom);
                end
            end
            step(); t++;
        end
        start = 1'b0;
        ct_ready = 1'b1;
        if (mode == 1) chk("backpressure_seen", int'(bp_done), 1);
        chk("done_seen", done_cnt - d0, 1);
        chk("read_count", rd_cnt, k*(D+1));
        chk("scoreboard_empty", exp_e.size(), 0);
        exp_e.delete();
        exp_i.delete();
        repeat (3) step();
        chk("done_once", done_cnt - d0, 1);
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        logic [N-1:0] m;
        int t;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_en", int'(pk_rd_en), 0);
        chk("rst_pk_addr", int'(pk_row_addr) + int'(pk_col_addr), 0);
        chk("rst_ct_valid", int'(ct_valid), 0);
        chk("rst_ct_out", int'(ct_entry) + int'(ct_index), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();

        fill_const(1);
        m = '0; m[0] = 1'b1; m[5] = 1'b1; m[29] = 1'b1;
        run_enc(5, m, 0);

        fill_const(1000);
        m = '0; m[0] = 1'b1; m[1] = 1'b1;
        run_enc(63, m, 0);

        run_enc(42, '0, 0);

        fill_rand();
        run_enc(int'($urandom_range(0, 63)), N'($urandom), 1);
        run_enc(int'($urandom_range(0, 63)), '1, 1);

        // Abort mid-read, then a fresh encryption must carry no residue.
        plaintext = PW'($urandom);
        rand_mask = '1;
        start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (!pk_rd_en && t < 100) begin step(); t++; end
        chk("reached_read", int'(pk_rd_en), 1);
        step(); step();
        rst_n = 1'b0;
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(pk_rd_en), 0);
        chk("abort_pk_addr", int'(pk_row_addr) + int'(pk_col_addr), 0);
        chk("abort_ct_valid", int'(ct_valid), 0);
        chk("abort_ct_out", int'(ct_entry) + int'(ct_index), 0);
        chk("abort_done", int'(done), 0);
        rst_n = 1'b1;
        step();
        fill_rand();
        run_enc(int'($urandom_range(0, 63)), N'($urandom), 0);

        rt_mode = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (n % 10 == 0) fill_lwe();
            run_enc(int'($urandom_range(0, 63)), N'($urandom), 2);
        end
        rt_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
